// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: one request at a time, LATENCY wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned H/HU/W accesses into access faults.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // initiator holds a request until accepted, the responder holds a response until taken.
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;

    logic [31:0] mem_array [DEPTH_WORDS];

    logic [31:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             in_range, f3_ok, misalign, acc_err;
    logic [31:0]      rd_word, load_data, wr_data;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [3:0]       be;
    logic             wr_en;

    // Access decode works on the latched request, so it is stable through WAIT/EXEC.
    always_comb begin
        word_off = (addr_q - BASE_ADDR) >> 2;
        idx      = word_off[IDX_W-1:0];
        in_range = (addr_q >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
        case (funct3_q)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !we_q;
            default:                f3_ok = 1'b0;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((funct3_q == 3'b010) && (addr_q[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        acc_err = !in_range || !f3_ok || misalign;

        rd_word = mem_array[idx];
        byte_v  = rd_word[{addr_q[1:0], 3'b000} +: 8];
        half_v  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_data = {24'h0, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b101:  load_data = {16'h0, half_v};
            3'b010:  load_data = rd_word;
            default: load_data = 32'h0;
        endcase

        case (funct3_q[1:0])
            2'b00: begin
                be      = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
        wr_en = (state_q == S_EXEC) && we_q && !acc_err;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_array[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        case (state_q)
            S_IDLE: begin
                if (!req_ready_q) begin
                    req_ready_d = 1'b1;
                end else if (req_valid) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    funct3_d    = req_funct3;
                    req_ready_d = 1'b0;
                    cnt_d       = 4'(LATENCY);
                    state_d     = (LATENCY == 0) ? S_EXEC : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_EXEC;
            end
            S_EXEC: begin
                resp_valid_d = 1'b1;
                resp_err_d   = acc_err;
                resp_rdata_d = (acc_err || we_q) ? 32'h0 : load_data;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            funct3_q     <= 3'b000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed load/store sequence, stall and reset cases, then random traffic
// checked against a byte-array reference model through an expected-response queue.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned LAT   = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];   // {err, rdata}
    int          acc_q[$];   // cycle in which each tracked request was accepted
    logic [7:0]  ref_mem [DEPTH*4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed little-endian memory, RV32I access rules.
    function automatic logic [32:0] model(input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [2:0] f3);
        logic [31:0] off;
        int unsigned b;
        logic        legal;
        off   = addr - BASE;
        legal = (addr >= BASE) && ((off / 4) < DEPTH);
        if (f3 == 3'd3 || f3 > 3'd5) legal = 1'b0;
        if (we && (f3 == 3'd4 || f3 == 3'd5)) legal = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) legal = 1'b0;
        if (f3 == 3'd2 && (addr % 4 != 0)) legal = 1'b0;
`endif
        if (!legal) return {1'b1, 32'h0};
        b = off;
        if (f3 == 3'd1 || f3 == 3'd5) b = b - (b % 2);
        if (f3 == 3'd2) b = b - (b % 4);
        if (we) begin
            ref_mem[b] = wdata[7:0];
            if (f3 != 3'd0) ref_mem[b+1] = wdata[15:8];
            if (f3 == 3'd2) begin
                ref_mem[b+2] = wdata[23:16];
                ref_mem[b+3] = wdata[31:24];
            end
            return {1'b0, 32'h0};
        end
        case (f3)
            3'd0:    return {1'b0, {24{ref_mem[b][7]}}, ref_mem[b]};
            3'd4:    return {1'b0, 24'h0, ref_mem[b]};
            3'd1:    return {1'b0, {16{ref_mem[b+1][7]}}, ref_mem[b+1], ref_mem[b]};
            3'd5:    return {1'b0, 16'h0, ref_mem[b+1], ref_mem[b]};
            default: return {1'b0, ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
        endcase
    endfunction

    // driver: present a request, hold it until accepted (bounded)
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input bit track);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (track) begin
                    exp_q.push_back(model(we, addr, wdata, f3));
                    acc_q.push_back(cyc);
                end
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        req_valid = 1'b0;
        chk("accept", 64'(done), 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // monitor: latency on each rising resp_valid, data on each response transfer
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (acc_q.size() == 0) chk("unexpected_resp_valid", 64'd1, 64'd0);
                else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT + 2));
            end
            if (resp_valid && resp_ready) begin
                chk("ready_low_in_resp", 64'(req_ready), 64'd0);
                if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
                else chk("resp", 64'({resp_err, resp_rdata}), 64'(exp_q.pop_front()));
            end
            prev_valid = resp_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] held;
        bit          seen;
        logic        we_r;
        logic [2:0]  f3_r;
        logic [31:0] a_r;

        // reset state
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("req_ready_before_edge", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("req_ready_after_edge", 64'(req_ready), 64'd1);

        // preload the working window so every load has a known answer
        for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), $urandom, 3'b010, 1'b1);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        do_req(1'b1, 32'h11, 32'h000000AA, 3'b000, 1'b1);
        do_req(1'b0, 32'h11, 32'h0, 3'b000, 1'b1);
        do_req(1'b0, 32'h11, 32'h0, 3'b100, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        do_req(1'b0, 32'h12, 32'h0, 3'b001, 1'b1);
        do_req(1'b0, 32'h12, 32'h0, 3'b101, 1'b1);
        do_req(1'b1, 32'h10, 32'h00001234, 3'b001, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        do_req(1'b0, 32'h1000, 32'h0, 3'b010, 1'b1);
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        do_req(1'b0, 32'h22, 32'h0, 3'b010, 1'b1);
        do_req(1'b0, 32'h13, 32'h0, 3'b011, 1'b1);
        wait_drain();

        // backpressure: response held stable, stray requests ignored
        @(posedge clk); #1 resp_ready = 1'b0;
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        chk("stall_resp_seen", 64'(seen), 64'd1);
        held = exp_q.size() != 0 ? exp_q[0] : 33'h0;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(resp_valid), 64'd1);
            chk("stall_data", 64'({resp_err, resp_rdata}), 64'(held));
            chk("stall_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", 64'(req_ready), 64'd1);
        chk("valid_after_release", 64'(resp_valid), 64'd0);
        do_req(1'b0, 32'h30, 32'h0, 3'b010, 1'b1);
        wait_drain();

        // reset during WAIT abandons the store
        do_req(1'b1, 32'h20, 32'h00000055, 3'b010, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_req_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("abort_req_ready_high", 64'(req_ready), 64'd1);
        chk("abort_no_resp", 64'(resp_valid), 64'd0);
        do_req(1'b0, 32'h20, 32'h0, 3'b010, 1'b1);
        wait_drain();

        // random traffic
        for (int n = 0; n < 200; n++) begin
            we_r = 1'($urandom_range(0, 1));
            f3_r = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a_r = 32'h1000 + 32'($urandom_range(0, 255));
                1:       a_r = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                default: a_r = 32'($urandom_range(0, 63));
            endcase
            do_req(we_r, a_r, $urandom, f3_r, 1'b1);
        end
        wait_drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
